cordic_pipe_arbiter: RTL and testbench
======================================

# cordic_pipe_arbiter

Round-robin arbiter and issue scheduler that shares the CORDIC rotation pipeline (pre-rotation stage onward) between two shape-request sources. It accepts requests over valid/ready handshakes, issues at most one item per cycle into the pipeline with a valid flag, and tags each issued item with its requester ID. The tag rides a fixed-latency shadow shift register, so results leaving the pipeline can be routed back. A credit counter bounds in-flight items to the capacity of the downstream result buffer, because the pipeline itself cannot stall.

## Interface
- PAYLOAD_W, 57, request payload width: {color[8:0], pixel_x[9:0], pixel_y[9:0], ref_x[8:0], ref_y[8:0], form, angle[8:0]}, MSB first.
- LATENCY, 12, pipeline depth in cycles from the pipe input register to the result (≥1).
- MAX_INFLIGHT, 8, downstream buffer entries (credits). CW = clog2(MAX_INFLIGHT+1).

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight items drain.
- req0_valid  in  1  requester 0 has an item.
- req0_data  in  PAYLOAD_W  requester 0 payload.
- req0_ready  out  1  combinational grant to requester 0.
- req1_valid / req1_data / req1_ready  same as requester 0, for requester 1.
- pipe_valid  out  1  registered; 1 = pipe_data is a real item (0 = bubble).
- pipe_data  out  PAYLOAD_W  registered payload to the pipeline input.
- ret_valid  in  1  pipeline output valid flag.
- ret_id  out  1  requester ID of the item leaving the pipeline this cycle.
- ret_id_valid  out  1  shadow tag valid this cycle.
- credit_return  in  1  one-cycle pulse; the consumer freed one buffer entry.
- inflight  out  CW  current credit usage.
- idle  out  1  inflight==0 and no tag in the shadow register.
- err  out  1  sticky error flag; cleared only by reset.

## Operation
- Grant condition: `can_issue = enable & (inflight < MAX_INFLIGHT)`.
- Round-robin, with a 1-bit `last` register (reset value 1, so requester 0 wins first).
  - Both valid: grant the requester ≠ `last`.
  - One valid: grant that requester.
  - `last` updates only on a grant.
- `reqN_ready = can_issue & grant==N`. At most one ready is high per cycle. ready never depends on reqN_valid of the other requester except through the priority rule.
- Transfer occurs when `reqN_valid & reqN_ready`. The transfer causes:
  - next edge: pipe_valid=1, pipe_data=reqN_data, id=N;
  - no transfer: pipe_valid=0, pipe_data holds its previous value.
- Shadow register: LATENCY entries of {valid,id}. It shifts every cycle unconditionally; the input is {pipe_valid, issued id}. The tail drives ret_id_valid/ret_id.
- Credit counter:
  - +1 on transfer; −1 on credit_return.
  - Both in the same cycle: unchanged.
  - credit_return with inflight==0 and no transfer: counter stays 0, err←1.
- Consistency check: any cycle with ret_valid ≠ ret_id_valid sets err←1. Routing still follows ret_id_valid.
- enable falling: takes effect the same cycle (ready drops combinationally). Items already registered continue through the pipeline.
- Reset mid-operation: the shadow register, counter, pipe_valid and err all clear immediately. Results still emerging from the pipeline afterward are reported only via err (mismatch). The team treats this as an external flush.

## Timing
- Reset values:
  - pipe_valid=0, pipe_data=0, ret_id=0, ret_id_valid=0, inflight=0, err=0, idle=1, `last`=1.
  - reqN_ready=0 while reset is high.
- Accept at cycle T → pipe_valid at T+1 → ret_id_valid at T+1+LATENCY.
- Throughput is 1 item/cycle while credits are available. With MAX_INFLIGHT < LATENCY+1, the sustained rate is limited by the credit_return rate.
- Full: inflight==MAX_INFLIGHT → both ready=0. A credit_return in the same cycle does not reopen the grant that cycle (the check uses the registered count); the grant reopens the next cycle.
- idle is registered-state combinational. It goes to 1 in the cycle after the last tag exits and the last credit returns.

## Test plan
- Reset then both valid continuously, enable=1, credit_return echoing ret_valid after 1 cycle, LATENCY=12 → grants alternate 0,1,0,1; ret_id sequence 0,1,0,1 starting 13 cycles after the first accept; err=0.
- Only req1 valid for 5 cycles, no credit_return, MAX_INFLIGHT=8 → 5 transfers; inflight=5; `last`=1; a new req0+req1 pair then grants req0.
- Fill credits: 8 accepts with no returns → both ready=0 from cycle 9. One credit_return pulse → exactly one grant the following cycle; inflight returns to 8.
- Simultaneous transfer and credit_return at inflight=3 → inflight stays 3. credit_return at inflight=0 → inflight stays 0 and err=1 (sticky).
- enable=0 mid-stream with 4 in flight → no new grants; 4 ret_id_valid pulses; idle=1 after the final credit_return. Force ret_valid=1 on a bubble slot → err=1.
- Assert reset for 1 cycle with 6 items in flight → all outputs are at their reset values within the reset cycle; the first grant after release goes to req0.

Source files
------------

// File: rtl/cordic_pipe_arbiter.sv
// Two-source round-robin issue scheduler for the shared CORDIC rotation pipeline.
// Tags each issued item with its requester ID through a fixed-latency shadow register and bounds in-flight items with credits.
module cordic_pipe_arbiter #(
   parameter  int PAYLOAD_W    = 57,
   parameter  int LATENCY      = 12,
   parameter  int MAX_INFLIGHT = 8,
   localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 req0_valid,
   input  logic [PAYLOAD_W-1:0] req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [PAYLOAD_W-1:0] req1_data,
   output logic                 req1_ready,
   output logic                 pipe_valid,
   output logic [PAYLOAD_W-1:0] pipe_data,
   input  logic                 ret_valid,
   output logic                 ret_id,
   output logic                 ret_id_valid,
   input  logic                 credit_return,
   output logic [CW-1:0]        inflight,
   output logic                 idle,
   output logic                 err
);

   logic                 last_q, last_d;
   logic                 pipe_valid_q, pipe_valid_d;
   logic                 pipe_id_q, pipe_id_d;
   logic [PAYLOAD_W-1:0] pipe_data_q, pipe_data_d;
   logic [CW-1:0]        inflight_q, inflight_d;
   logic                 err_q, err_d;
   logic [LATENCY-1:0]   tag_valid_q, tag_valid_d;
   logic [LATENCY-1:0]   tag_id_q, tag_id_d;

   logic can_issue;
   logic grant_id;
   logic xfer;
   logic underflow;

   // Full check uses the registered count, so a same-cycle credit_return cannot reopen the grant.
   assign can_issue = enable & ~reset & (inflight_q < CW'(MAX_INFLIGHT));

   always_comb begin
      grant_id = ~last_q;
      if (req0_valid & ~req1_valid) begin
         grant_id = 1'b0;
      end else if (req1_valid & ~req0_valid) begin
         grant_id = 1'b1;
      end
   end

   assign req0_ready = can_issue & ~grant_id;
   assign req1_ready = can_issue & grant_id;
   assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   always_comb begin
      last_d       = last_q;
      pipe_valid_d = xfer;
      pipe_id_d    = pipe_id_q;
      pipe_data_d  = pipe_data_q;
      if (xfer) begin
         last_d      = grant_id;
         pipe_id_d   = grant_id;
         pipe_data_d = grant_id ? req1_data : req0_data;
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      underflow  = 1'b0;
      if (xfer & ~credit_return) begin
         inflight_d = inflight_q + CW'(1);
      end else if (~xfer & credit_return) begin
         if (inflight_q == '0) begin
            underflow = 1'b1;
         end else begin
            inflight_d = inflight_q - CW'(1);
         end
      end
   end

   always_comb begin
      err_d = err_q | underflow | (ret_valid != tag_valid_q[LATENCY-1]);
   end

   // Shadow tag line: stage 0 takes the pipe input register, the last stage lines up with the pipeline output.
   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_shadow
         if (gi == 0) begin : g_head
            assign tag_valid_d[gi] = pipe_valid_q;
            assign tag_id_d[gi]    = pipe_id_q;
         end else begin : g_body
            assign tag_valid_d[gi] = tag_valid_q[gi-1];
            assign tag_id_d[gi]    = tag_id_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q       <= 1'b1;
         pipe_valid_q <= 1'b0;
         pipe_id_q    <= 1'b0;
         pipe_data_q  <= '0;
         inflight_q   <= '0;
         err_q        <= 1'b0;
         tag_valid_q  <= '0;
         tag_id_q     <= '0;
      end else begin
         last_q       <= last_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_id_q    <= pipe_id_d;
         pipe_data_q  <= pipe_data_d;
         inflight_q   <= inflight_d;
         err_q        <= err_d;
         tag_valid_q  <= tag_valid_d;
         tag_id_q     <= tag_id_d;
      end
   end

   assign pipe_valid   = pipe_valid_q;
   assign pipe_data    = pipe_data_q;
   assign ret_id_valid = tag_valid_q[LATENCY-1];
   assign ret_id       = tag_id_q[LATENCY-1];
   assign inflight     = inflight_q;
   assign err          = err_q;
   assign idle         = (inflight_q == '0) & ~(|tag_valid_q);

endmodule

// File: tb/tb_cordic_pipe_arbiter.sv
// Self-checking bench for cordic_pipe_arbiter: grant table, hand-written corner sequences and a randomized run
// against a scheduling model that tracks each accepted item by the cycle its tag must emerge.
module tb_cordic_pipe_arbiter;
   localparam int PW   = 57;
   localparam int LAT  = 12;
   localparam int MAXI = 8;
   localparam int CW   = $clog2(MAXI + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [PW-1:0] req0_data = '0, req1_data = '0;
   logic          ret_valid = 1'b0, credit_return = 1'b0;
   logic          req0_ready, req1_ready, pipe_valid, ret_id, ret_id_valid, idle, err;
   logic [PW-1:0] pipe_data;
   logic [CW-1:0] inflight;

   cordic_pipe_arbiter #(.PAYLOAD_W(PW), .LATENCY(LAT), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .pipe_valid(pipe_valid), .pipe_data(pipe_data),
      .ret_valid(ret_valid), .ret_id(ret_id), .ret_id_valid(ret_id_valid),
      .credit_return(credit_return), .inflight(inflight), .idle(idle), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: item counts, arbitration memory, and a map from exit cycle to requester ID.
   int            m_inflight;
   bit            m_last, m_err, m_pv;
   logic [PW-1:0] m_pd;
   int            sched[int];
   bit            auto_cr = 0, cr_man = 0, bad_ret = 0, prev_ret = 0;
   int            obs_cyc[$];
   int            obs_id[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit exp_idle();
      if (m_inflight != 0) return 0;
      foreach (sched[k]) if (k >= cyc && k <= cyc + LAT - 1) return 0;
      return 1;
   endfunction

   function automatic bit pick();
      if (req0_valid && req1_valid) return !m_last;
      return req1_valid && !req0_valid;
   endfunction

   task automatic tick_pre();
      bit can, g;
      ret_valid     = sched.exists(cyc) ^ bad_ret;
      credit_return = auto_cr ? prev_ret : cr_man;
      #3;
      can = enable && !reset && (m_inflight < MAXI);
      g   = pick();
      if (reset || req0_valid || req1_valid) begin
         chk("req0_ready", req0_ready, can && !g);
         chk("req1_ready", req1_ready, can && g);
      end
      chk("pipe_valid", pipe_valid, m_pv);
      chk("pipe_data", pipe_data, m_pd);
      chk("ret_id_valid", ret_id_valid, sched.exists(cyc));
      if (sched.exists(cyc)) chk("ret_id", ret_id, sched[cyc]);
      chk("inflight", inflight, m_inflight);
      chk("idle", idle, exp_idle());
      chk("err", err, m_err);
      if (ret_id_valid === 1'b1) begin
         obs_cyc.push_back(cyc);
         obs_id.push_back(int'(ret_id));
      end
   endtask

   task automatic tick_post();
      bit can, g, tr;
      int k;
      can = enable && !reset && (m_inflight < MAXI);
      g   = pick();
      tr  = can && ((!g && req0_valid) || (g && req1_valid));
      @(posedge clk);
      if (!reset) begin
         if (ret_valid != sched.exists(cyc)) m_err = 1;
         if (tr && !credit_return) m_inflight++;
         else if (!tr && credit_return) begin
            if (m_inflight == 0) m_err = 1;
            else m_inflight--;
         end
         m_pv = tr;
         if (tr) begin
            m_last = g;
            m_pd   = g ? req1_data : req0_data;
            sched[cyc + 1 + LAT] = int'(g);
         end
      end
      prev_ret = ret_valid && !reset;
      cyc++;
      while (sched.first(k) && k < cyc) sched.delete(k);
      #1;
   endtask

   task automatic tick();
      tick_pre();
      tick_post();
   endtask

   task automatic rand_data();
      req0_data = {$urandom, $urandom};
      req1_data = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_inflight = 0; m_last = 1; m_err = 0; m_pv = 0; m_pd = '0;
      sched.delete();
      prev_ret = 0;
      tick_pre();
      chk("reset_ret_id", ret_id, 0);
      chk("reset_idle", idle, 1);
      tick_post();
      reset = 1'b0;
   endtask

   typedef struct {
      bit en, v0, v1;
      bit r0, r1;
      int infl;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      int   c0, n;
      tbl[0] = '{1, 1, 1, 1, 0, 0};
      tbl[1] = '{1, 1, 1, 0, 1, 1};
      tbl[2] = '{1, 0, 1, 0, 1, 2};
      tbl[3] = '{1, 1, 1, 1, 0, 3};
      tbl[4] = '{0, 1, 1, 0, 0, 4};
      tbl[5] = '{1, 1, 0, 1, 0, 4};
      tbl[6] = '{1, 1, 1, 0, 1, 5};

      #1;
      do_reset();

      // Grant table from reset.
      foreach (tbl[i]) begin
         enable = tbl[i].en; req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
         rand_data();
         tick_pre();
         chk("tbl_r0", req0_ready, tbl[i].r0);
         chk("tbl_r1", req1_ready, tbl[i].r1);
         chk("tbl_inflight", inflight, tbl[i].infl);
         $display("vec %0d en=%0b v0=%0b v1=%0b -> r0=%0b r1=%0b inflight=%0d", i, enable,
                  req0_valid, req1_valid, req0_ready, req1_ready, inflight);
         tick_post();
      end

      // Both requesters streaming, credits echo ret_valid a cycle later.
      do_reset();
      enable = 1; req0_valid = 1; req1_valid = 1; auto_cr = 1;
      obs_cyc.delete(); obs_id.delete();
      c0 = cyc;
      for (int i = 0; i < 40; i++) begin rand_data(); tick(); end
      chk("A_ret_count_ge4", obs_id.size() >= 4, 1);
      if (obs_id.size() >= 4) begin
         chk("A_first_ret_latency", obs_cyc[0] - c0, LAT + 1);
         chk("A_ret_id0", obs_id[0], 0);
         chk("A_ret_id1", obs_id[1], 1);
         chk("A_ret_id2", obs_id[2], 0);
         chk("A_ret_id3", obs_id[3], 1);
      end
      chk("A_err", err, 0);
      auto_cr = 0;

      // Only req1 for five cycles, then a pair goes to req0.
      do_reset();
      enable = 1; req0_valid = 0; req1_valid = 1;
      for (int i = 0; i < 5; i++) begin rand_data(); tick(); end
      chk("B_inflight5", inflight, 5);
      req0_valid = 1;
      rand_data();
      tick_pre();
      chk("B_pair_r0", req0_ready, 1);
      chk("B_pair_r1", req1_ready, 0);
      tick_post();

      // Fill the credits, then one return reopens exactly one grant a cycle later.
      for (int i = 0; i < 20 && inflight != MAXI; i++) begin rand_data(); tick(); end
      chk("C_full", inflight, MAXI);
      cr_man = 1;
      tick_pre();
      chk("C_same_cycle_r", {req0_ready, req1_ready}, 0);
      tick_post();
      cr_man = 0;
      tick_pre();
      chk("C_one_grant", req0_ready ^ req1_ready, 1);
      tick_post();
      tick_pre();
      chk("C_refilled", inflight, MAXI);
      chk("C_closed", {req0_ready, req1_ready}, 0);
      tick_post();

      // Transfer and return together, then underflow.
      do_reset();
      enable = 1; req0_valid = 0; req1_valid = 1;
      for (int i = 0; i < 3; i++) begin rand_data(); tick(); end
      cr_man = 1;
      tick_pre();
      chk("D_pre3", inflight, 3);
      chk("D_xfer", req1_ready, 1);
      tick_post();
      req1_valid = 0;
      tick_pre();
      chk("D_hold3", inflight, 3);
      tick_post();
      tick(); tick();
      tick_pre();
      chk("D_zero", inflight, 0);
      tick_post();
      cr_man = 0;
      tick_pre();
      chk("D_underflow_inflight", inflight, 0);
      chk("D_underflow_err", err, 1);
      tick_post();
      for (int i = 0; i < 3; i++) tick();
      tick_pre();
      chk("D_err_sticky", err, 1);
      tick_post();

      // Drain with enable low, then a spurious ret_valid.
      do_reset();
      enable = 1; req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 4; i++) begin rand_data(); tick(); end
      enable = 0; auto_cr = 1;
      obs_cyc.delete(); obs_id.delete();
      for (int i = 0; i < 30; i++) tick();
      n = obs_id.size();
      chk("E_ret_pulses", n, 4);
      chk("E_idle", idle, 1);
      chk("E_inflight", inflight, 0);
      auto_cr = 0; bad_ret = 1;
      tick();
      bad_ret = 0;
      tick_pre();
      chk("E_bubble_err", err, 1);
      tick_post();

      // Reset with six in flight.
      do_reset();
      enable = 1;
      for (int i = 0; i < 6; i++) begin rand_data(); tick(); end
      chk("F_pre_inflight", inflight, 6);
      reset = 1;
      #1;
      chk("F_rst_inflight", inflight, 0);
      chk("F_rst_pipe_valid", pipe_valid, 0);
      chk("F_rst_pipe_data", pipe_data, 0);
      chk("F_rst_ready", {req0_ready, req1_ready}, 0);
      chk("F_rst_idle", idle, 1);
      chk("F_rst_err", err, 0);
      #(-1 + 1);
      do_reset();
      tick_pre();
      chk("F_first_grant_r0", req0_ready, 1);
      tick_post();

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         enable     = ($urandom % 8) != 0;
         req0_valid = $urandom % 2;
         req1_valid = $urandom % 2;
         cr_man     = (m_inflight > 0) && ($urandom % 3 == 0);
         rand_data();
         if ($urandom % 500 == 0) do_reset();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
